// File: rtl/ex_stage.sv
// ----------------------------------------------------------------------------
// ex_stage: execute stage of a 5-stage MIPS-style pipeline.
//
// What it does
//   - Selects the forwarded A and B operands.
//   - Contains the ALU and the destination-register mux.
//   - Contains a multi-cycle multiply/divide unit (MDU) that owns the HI and
//     LO registers.
//
// Ports
//   clk, reset         Rising-edge clock. reset is asynchronous, active low.
//   ALUSrc             Selects the ALU B input: 1 = sign_extended, 0 = the
//                      forwarded rt value.
//   ALUOp              ALU class. 00 add, 01 sub, 11 or, 10 decode by funct.
//   RegDst             Selects the destination register: 1 = rd, 0 = rt.
//   RDdata1, RDdata2,  Operands from the ID/EX register.
//   sign_extended
//   rt, rd, funct      Instruction fields.
//   fwd_a, fwd_b       Forwarding selects: 10 = EX/MEM, 01 = MEM/WB,
//                      00/11 = register file.
//   exmem_result,      Forwarded values.
//   memwb_result
//   alu_result, zero   ALU output, and a flag that is 1 when alu_result == 0.
//   write_reg          Destination register number.
//   store_data         Forwarded rt value, used by stores.
//   stall              Hold request to PC, IF/ID and ID/EX while the MDU runs.
// ----------------------------------------------------------------------------
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ALUSrc,
    input  logic [1:0]  ALUOp,
    input  logic        RegDst,
    input  logic [31:0] RDdata1,
    input  logic [31:0] RDdata2,
    input  logic [31:0] sign_extended,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    input  logic [1:0]  fwd_a,
    input  logic [1:0]  fwd_b,
    input  logic [31:0] exmem_result,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_result,
    output logic        zero,
    output logic [4:0]  write_reg,
    output logic [31:0] store_data,
    output logic        stall
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_fb;
    logic [31:0] alu_b;

    always_comb begin
        case (fwd_a)
            2'b10:   op_a = exmem_result;
            2'b01:   op_a = memwb_result;
            default: op_a = RDdata1;
        endcase
        case (fwd_b)
            2'b10:   op_fb = exmem_result;
            2'b01:   op_fb = memwb_result;
            default: op_fb = RDdata2;
        endcase
        alu_b = ALUSrc ? sign_extended : op_fb;
    end

    assign store_data = op_fb;
    assign write_reg  = RegDst ? rd : rt;

    // ------------------------------------------------------------------
    // MDU state
    // ------------------------------------------------------------------
    mdu_state_t  state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [63:0] acc_q,   acc_d;   // multiply: {partial, multiplier}; divide: {rem, quot}
    logic [31:0] opb_q,   opb_d;   // multiplicand or divisor
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    logic        mul_req;
    logic        div_req;

    assign mul_req = (ALUOp == 2'b10) && (funct == F_MULTU);
    assign div_req = (ALUOp == 2'b10) && (funct == F_DIVU);

    // One shift-add step. The 33-bit sum keeps the carry, which becomes
    // the new top bit when the accumulator shifts right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    // One restoring-division step. The remainder stays below the divisor,
    // so after a subtraction the result always fits in 32 bits. A zero
    // divisor makes every step "succeed". That gives an all-ones quotient
    // and leaves the dividend as the remainder.
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem;
    logic [63:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opb_q : 32'd0)};
        mul_next  = {mul_sum, acc_q[31:1]};

        div_shift = {acc_q[63:32], acc_q[31]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        div_rem   = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
        div_next  = {div_rem, acc_q[30:0], div_ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;

        case (state_q)
            IDLE: begin
                // Gate with reset so the hold request drops while reset is held.
                stall = (mul_req || div_req) && reset;
                if (mul_req || div_req) begin
                    acc_d   = {32'd0, op_a};
                    opb_d   = alu_b;
                    cnt_d   = 5'd0;
                    state_d = mul_req ? MUL : DIV;
                end
            end
            MUL: begin
                stall = 1'b1;
                acc_d = mul_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = mul_next[63:32];
                    lo_d    = mul_next[31:0];
                    state_d = DONE;
                end
            end
            DIV: begin
                stall = 1'b1;
                acc_d = div_next;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    hi_d    = div_next[63:32];
                    lo_d    = div_next[31:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                // Always return to IDLE for one cycle, even if an MDU
                // instruction is still presented.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 64'd0;
            opb_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // ALU
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = 32'd0;
        case (ALUOp)
            2'b00: alu_result = op_a + alu_b;
            2'b01: alu_result = op_a - alu_b;
            2'b11: alu_result = op_a | alu_b;
            default: begin
                // multu, divu and undefined funct codes leave the result at 0.
                case (funct)
                    F_ADD:   alu_result = op_a + alu_b;
                    F_SUB:   alu_result = op_a - alu_b;
                    F_AND:   alu_result = op_a & alu_b;
                    F_OR:    alu_result = op_a | alu_b;
                    F_SLT:   alu_result = {31'd0, ($signed(op_a) < $signed(alu_b))};
                    F_MFHI:  alu_result = hi_q;
                    F_MFLO:  alu_result = lo_q;
                    default: alu_result = 32'd0;
                endcase
            end
        endcase
    end

    assign zero = (alu_result == 32'd0);

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: ALUSrc  in  1  B-operand select; ALUOp  in  2  ALU class; RegDst  in  1  destination select.
REQ-003 SHALL have ports: RDdata1, RDdata2, sign_extended  in  32 each  operands from ID/EX register.
REQ-004 SHALL have ports: rt, rd  in  5 each  instruction fields [20:16], [15:11]; funct  in  6  instruction [5:0].
REQ-005 SHALL have ports: fwd_a, fwd_b  in  2 each  forward selects; exmem_result, memwb_result  in  32 each  forwarded values.
REQ-006 SHALL have ports: alu_result  out  32; zero  out  1; write_reg  out  5; store_data  out  32; stall  out  1  hold request to PC, IF/ID and ID/EX.

Function
REQ-007 Operand A SHALL be: fwd_a=10 exmem_result, 01 memwb_result, 00/11 RDdata1. Forwarded B (fb) SHALL use the same mapping on fwd_b and RDdata2.
REQ-008 store_data SHALL equal fb. ALU B SHALL equal sign_extended when ALUSrc=1, else fb.
REQ-009 write_reg SHALL equal rd when RegDst=1, else rt. zero SHALL be 1 iff alu_result==0.
REQ-010 ALUOp 00 -> A+B; 01 -> A-B; 11 -> A|B; 10 -> decode by funct.
REQ-011 funct decode SHALL be: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 signed slt (result 1 or 0), 010000 mfhi (HI), 010010 mflo (LO), 011001 multu, 011011 divu.
REQ-012 multu, divu and undefined funct SHALL give alu_result 0. Add/sub SHALL wrap modulo 2^32 with no overflow trap.
REQ-013 HI, LO SHALL be 32-bit internal registers written only by the MDU.
REQ-014 MDU FSM states SHALL be IDLE, MUL, DIV, DONE, with a 5-bit iteration counter.
REQ-015 IDLE with ALUOp=10 and funct multu/divu: SHALL latch A and B at the clock edge, clear the counter, and go to MUL or DIV.
REQ-016 MUL SHALL do unsigned shift-add and DIV unsigned restoring division, one bit per cycle, 32 cycles. After the 32nd iteration (counter 31) the FSM SHALL write HI/LO and go to DONE.
REQ-017 multu result: {HI,LO} = 64-bit product. divu result: LO = quotient, HI = remainder.
REQ-018 Divide by zero SHALL give LO=0xFFFFFFFF and HI=dividend, with no exception.
REQ-019 DONE SHALL go to IDLE unconditionally, with no restart even if multu/divu is still presented.
REQ-020 stall SHALL be combinational:
- 1 in IDLE while multu/divu is presented;
- 1 in MUL and DIV;
- 0 in DONE.
- Total: 33 consecutive stall cycles per MDU op.
REQ-021 mfhi/mflo in the cycle after DONE SHALL read the updated HI/LO (no hazard).
REQ-022 All outputs except stall SHALL be combinational from the current inputs and HI/LO.

Reset
REQ-023 While reset=0 (asynchronous): FSM=IDLE, counter=0, HI=LO=0, MDU operand/accumulator registers=0, stall=0.
REQ-024 Reset mid-operation SHALL abort the MDU with no HI/LO update. After release, an MDU op still presented SHALL start fresh from IDLE.
REQ-025 Combinational outputs SHALL follow inputs during reset; with all-zero inputs: alu_result=0, zero=1, write_reg=0, store_data=0.

Verification
REQ-026 ALUOp=10, funct=100000, RDdata1=5, RDdata2=7, ALUSrc=0 -> alu_result=12, zero=0.
REQ-027 ALUOp=01, A=B=0x00001234 -> alu_result=0, zero=1. Then RegDst=0, rt=9 -> write_reg=9.
REQ-028 ALUOp=00, ALUSrc=1, sign_extended=4, fwd_a=10, exmem_result=0x10, RDdata1=0xFF -> alu_result=0x14. With fwd_b=01, memwb_result=0xAB -> store_data=0xAB.
REQ-029 multu A=0xFFFFFFFF, B=2 -> stall=1 for exactly 33 cycles, then 0. Next mfhi -> 1; mflo -> 0xFFFFFFFE.
REQ-030 divu 100/7 -> LO=14, HI=2. divu 0x55/0 -> LO=0xFFFFFFFF, HI=0x55.
REQ-031 reset=0 on stall cycle 10 of a multu -> stall=0 immediately, HI=LO=0. After release with multu held, stall=1 for 33 cycles again.
